// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the Booth multiplier sequencer: FSM encoding,
// operand/product widths and the most-negative operand constants.
package booth_mult_pkg;

    localparam int OP_W   = 8;
    localparam int STEPS  = OP_W;
    localparam int PROD_W = 2 * OP_W;

    // Most-negative operand; the multiplier's accumulator cannot subtract it safely.
    localparam logic [OP_W-1:0]   MOST_NEG    = 8'h80;
    // Exact product of MOST_NEG * MOST_NEG (+2^(2*OP_W-2)).
    localparam logic [PROD_W-1:0] MOST_NEG_SQ = 16'h4000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Bus bundle between upstream producer, the sequencer, the Booth multiplier
// and the downstream consumer. The sequencer uses the slave modport; the
// environment around it (source, multiplier, sink) uses master.
interface booth_mult_ctrl_if
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = OP_W
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [WIDTH-1:0]     mult_a;
    logic [WIDTH-1:0]     mult_b;
    logic                 mult_check;
    logic [2*WIDTH-1:0]   mult_product;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 err;
    logic                 busy;

    modport master (
        output in_valid, a_in, b_in, mult_product, out_ready,
        input  in_ready, mult_a, mult_b, mult_check, out_valid, product, err, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, mult_product, out_ready,
        output in_ready, mult_a, mult_b, mult_check, out_valid, product, err, busy
    );

endinterface

// File: rtl/booth_mult_ctrl_step_counter.sv
// Booth step counter: synchronous clear, count enable and a terminal-count
// flag raised while the count equals TERM.
module booth_step_counter #(
    parameter int CNT_W = 4,
    parameter int TERM  = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (en) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TERM_C);

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencer in front of the 8-bit Booth multiplier: accepts an operand pair,
// pulses the multiplier's load (check) for one cycle, waits STEPS step
// cycles, captures FinalProduct and offers it downstream.
// Optional build macro BOOTH_SWAP_EN: swaps a most-negative multiplicand into
// the multiplier slot and forces the exact result (with err) when both
// operands are most-negative.
module booth_mult_ctrl
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = OP_W,
    parameter int STEPS = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mult_ctrl_if.slave   bus
);

    localparam int CNT_W  = $clog2(STEPS + 1);
    localparam int PROD_W_L = 2 * WIDTH;

`ifdef BOOTH_SWAP_EN
    // Width-generic forms of MOST_NEG / MOST_NEG_SQ.
    localparam logic [WIDTH-1:0]    MOST_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PROD_W_L-1:0] NEG_SQ_W   = {2'b01, {(PROD_W_L-2){1'b0}}};
`endif

    state_e                 state_q;
    state_e                 state_d;

    logic [WIDTH-1:0]       mult_a_q;
    logic [WIDTH-1:0]       mult_a_d;
    logic [WIDTH-1:0]       mult_b_q;
    logic [WIDTH-1:0]       mult_b_d;
    logic [PROD_W_L-1:0]    product_q;
    logic [PROD_W_L-1:0]    product_d;
    logic                   err_q;
    logic                   err_d;
    logic                   mult_check_q;
    logic                   mult_check_d;
    logic                   in_ready_q;
    logic                   in_ready_d;
    logic                   out_valid_q;
    logic                   out_valid_d;
    logic                   busy_q;
    logic                   busy_d;
`ifdef BOOTH_SWAP_EN
    logic                   both_neg_q;
    logic                   both_neg_d;
`endif

    logic                   accept_s;
    logic                   step_tc_s;
    logic                   cnt_clr_s;
    logic                   cnt_en_s;

    assign accept_s  = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
    assign cnt_clr_s = (state_q == ST_LOAD);
    assign cnt_en_s  = (state_q == ST_RUN);

    booth_step_counter #(
        .CNT_W (CNT_W),
        .TERM  (STEPS - 1)
    ) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (step_tc_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one operation in flight, no overlap with the result hand-off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (step_tc_s) begin
                    state_d = ST_CAPT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CAPT: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; status flags decode the next state so they are registered.
    always_comb begin
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        product_d    = product_q;
        err_d        = err_q;
`ifdef BOOTH_SWAP_EN
        both_neg_d   = both_neg_q;
`endif
        mult_check_d = (state_d == ST_LOAD);
        in_ready_d   = (state_d == ST_IDLE);
        out_valid_d  = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);

        if (accept_s) begin
`ifdef BOOTH_SWAP_EN
            // Keep -M out of the multiplicand slot unless both operands are -M.
            if ((bus.a_in == MOST_NEG_W) && (bus.b_in != MOST_NEG_W)) begin
                mult_a_d = bus.b_in;
                mult_b_d = bus.a_in;
            end else begin
                mult_a_d = bus.a_in;
                mult_b_d = bus.b_in;
            end
            both_neg_d = (bus.a_in == MOST_NEG_W) && (bus.b_in == MOST_NEG_W);
`else
            mult_a_d = bus.a_in;
            mult_b_d = bus.b_in;
`endif
        end else begin
            mult_a_d = mult_a_q;
            mult_b_d = mult_b_q;
        end

        // Capture the pre-edge FinalProduct; the multiplier's extra step this cycle lands after it.
        if (state_q == ST_CAPT) begin
`ifdef BOOTH_SWAP_EN
            if (both_neg_q) begin
                product_d = NEG_SQ_W;
                err_d     = 1'b1;
            end else begin
                product_d = bus.mult_product;
                err_d     = 1'b0;
            end
`else
            product_d = bus.mult_product;
            err_d     = 1'b0;
`endif
        end else begin
            product_d = product_q;
            err_d     = err_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a_q     <= {WIDTH{1'b0}};
            mult_b_q     <= {WIDTH{1'b0}};
            product_q    <= {PROD_W_L{1'b0}};
            err_q        <= 1'b0;
            mult_check_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BOOTH_SWAP_EN
            both_neg_q   <= 1'b0;
`endif
        end else begin
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            product_q    <= product_d;
            err_q        <= err_d;
            mult_check_q <= mult_check_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
`ifdef BOOTH_SWAP_EN
            both_neg_q   <= both_neg_d;
`endif
        end
    end

    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.mult_check = mult_check_q;
    assign bus.product    = product_q;
    assign bus.err        = err_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed cases plus randomized
// operand pairs, with a behavioural Booth multiplier stand-in and an
// arithmetic reference for the expected product and multiplier operands.
module tb_booth_mult_ctrl;
    import booth_mult_pkg::*;

    localparam int W  = 8;
    localparam int NS = W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_mult_ctrl_if #(.WIDTH(W)) bus ();

    booth_mult_ctrl #(.WIDTH(W), .STEPS(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier stand-in: loads on check, result valid only after exactly NS steps.
    logic [7:0] m_a;
    logic [7:0] m_b;
    int         m_steps;
    bit         m_loaded;

    initial begin
        m_a = 8'h00; m_b = 8'h00; m_steps = 0; m_loaded = 1'b0;
    end

    function automatic logic [15:0] mult_model(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        if (a == 8'h80) p = ~p;   // accumulator overflow when subtracting -128
        return p[15:0];
    endfunction

    always @(posedge clk) begin
        if (bus.mult_check) begin
            m_a      <= bus.mult_a;
            m_b      <= bus.mult_b;
            m_steps  <= 0;
            m_loaded <= 1'b1;
        end else if (m_loaded) begin
            m_steps <= m_steps + 1;
        end
    end

    assign bus.mult_product = (m_loaded && m_steps == NS) ? mult_model(m_a, m_b) : 16'hDEAD;

    // Reference: expected multiplier operands, product and err.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] ea, output logic [7:0] eb,
                                   output logic [15:0] ep, output bit ee);
        int p;
        p  = int'($signed(a)) * int'($signed(b));
        ea = a;
        eb = b;
        ep = p[15:0];
        ee = 1'b0;
`ifdef BOOTH_SWAP_EN
        if (a == 8'h80 && b != 8'h80) begin
            ea = b;
            eb = a;
        end
        if (a == 8'h80 && b == 8'h80) begin
            ep = 16'h4000;
            ee = 1'b1;
        end
`endif
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int bp,
                         input bit early, input string tag);
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [15:0] ep;
        bit          ee;
        int          cyc;
        int          npulse;
        ref_op(a, b, ea, eb, ep, ee);
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1; bus.out_ready = early;
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: must be ignored while busy.
        bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
        cyc = 0; npulse = 0;
        check_eq({tag, "_ma0"}, {24'd0, bus.mult_a}, {24'd0, ea});
        check_eq({tag, "_mb0"}, {24'd0, bus.mult_b}, {24'd0, eb});
        check_eq({tag, "_busy"}, {30'd0, bus.busy, bus.in_ready}, 32'd2);
        if (bus.mult_check === 1'b1) npulse++;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (bus.mult_check === 1'b1) npulse++;
        end
        check_eq({tag, "_lat"}, cyc, NS + 2);
        check_eq({tag, "_ldpulse"}, npulse, 32'd1);
        check_eq({tag, "_prod"}, {16'd0, bus.product}, {16'd0, ep});
        check_eq({tag, "_err"}, {31'd0, bus.err}, {31'd0, ee});
        check_eq({tag, "_mahold"}, {16'd0, bus.mult_a, bus.mult_b}, {16'd0, ea, eb});
        if (!early) begin
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                check_eq({tag, "_bp_prod"}, {16'd0, bus.product}, {16'd0, ep});
                check_eq({tag, "_bp_flags"}, {29'd0, bus.out_valid, bus.in_ready, bus.err},
                         {29'd0, 1'b1, 1'b0, ee});
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check_eq({tag, "_idle"}, {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
    endtask

    task automatic reset_mid(input logic [7:0] a, input logic [7:0] b);
        int cyc;
        int spurious;
        bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Step count reaches 4 in the cycle after the 5th edge past accept.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_flags", {28'd0, bus.out_valid, bus.busy, bus.mult_check, bus.in_ready},
                 32'd1);
        check_eq("rst_mid_prod", {16'd0, bus.product}, 32'd0);
        check_eq("rst_mid_ops", {16'd0, bus.mult_a, bus.mult_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) spurious++;
        end
        check_eq("rst_no_result", spurious, 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        bus.in_valid  = 1'b0;
        bus.a_in      = 8'h00;
        bus.b_in      = 8'h00;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_flags", {28'd0, bus.in_ready, bus.out_valid, bus.busy, bus.mult_check},
                 32'd8);
        check_eq("rst_data", {bus.product, bus.mult_a, bus.mult_b}, 32'd0);
        check_eq("rst_err", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h05, 8'h03, 0, 1'b1, "d_5x3");
        do_op(8'hF9, 8'h06, 2, 1'b0, "d_m7x6");
        do_op(8'h7F, 8'h80, 0, 1'b0, "d_127xm128");
`ifdef BOOTH_SWAP_EN
        do_op(8'h80, 8'h03, 1, 1'b0, "d_swap");
        do_op(8'h80, 8'h80, 0, 1'b1, "d_negneg");
`endif
        do_op(8'h33, 8'hC5, 5, 1'b0, "d_bp");
        do_op(8'h00, 8'h81, 0, 1'b1, "d_zero");

        reset_mid(8'h11, 8'h22);
        do_op(8'h02, 8'h02, 0, 1'b0, "d_post_rst");

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef BOOTH_SWAP_EN
            if ($urandom_range(0, 7) == 0) ra = 8'h80;
`else
            if (ra == 8'h80) ra = 8'h81;
`endif
            do_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
